// File: rtl/i2c_slave_responder.sv
// ---------------------------------------------------------------------------
// i2c_slave_responder
//   I2C target that oversamples SCL/SDA on pclk and matches a 7-bit address.
//   It takes a register pointer byte, then services write bursts and read
//   bursts against an internal byte-wide register file. The pointer
//   auto-increments and keeps its value across transactions.
//
// Ports
//   pclk, areset    system clock and synchronous active-high reset
//   slave_address   this device's address, static during a transfer
//   scl_i, sda_i    pad inputs (asynchronous to pclk)
//   sda_oen         1 = pull SDA low, 0 = release
//   busy            high from an address match until START/STOP
//   wr_strobe       one-pclk pulse per register written, with wr_addr/wr_data
//   dbg_addr        backdoor read address
//   dbg_data        combinational register file value at dbg_addr
// ---------------------------------------------------------------------------
module i2c_slave_responder #(
  parameter int SLAVE_ADDRESS_WIDTH    = 7,
  parameter int REGISTER_ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH             = 8
) (
  input  logic                              pclk,
  input  logic                              areset,
  input  logic [SLAVE_ADDRESS_WIDTH-1:0]    slave_address,
  input  logic                              scl_i,
  input  logic                              sda_i,
  output logic                              sda_oen,
  output logic                              busy,
  output logic                              wr_strobe,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]             wr_data,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]             dbg_data
);

  localparam int DEPTH = 1 << REGISTER_ADDRESS_WIDTH;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    REG_PTR   = 4'd3,
    PTR_ACK   = 4'd4,
    WR_DATA   = 4'd5,
    WR_ACK    = 4'd6,
    RD_DATA   = 4'd7,
    RD_ACK    = 4'd8,
    WAIT_STOP = 4'd9
  } state_e;

  state_e                            state_q, state_d;
  logic [3:0]                        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]             shift_q, shift_d;
  logic [REGISTER_ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
  logic                              rw_q, rw_d;
  logic                              sda_oen_q, sda_oen_d;
  logic                              busy_q, busy_d;
  logic                              wr_strobe_q, wr_strobe_d;
  logic [REGISTER_ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]             wr_data_q, wr_data_d;

  // [0],[1] form the synchronizer, [2] is the history flop for edge detection
  logic [2:0] scl_sync_q;
  logic [2:0] sda_sync_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we_s;

  logic                              scl_s, scl_h, sda_s, sda_h;
  logic                              scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [DATA_WIDTH-1:0]             rx_byte_s;
  logic [DATA_WIDTH-1:0]             rd_byte_s;
  logic [REGISTER_ADDRESS_WIDTH-1:0] ptr_inc_s;

  assign scl_s      = scl_sync_q[1];
  assign scl_h      = scl_sync_q[2];
  assign sda_s      = sda_sync_q[1];
  assign sda_h      = sda_sync_q[2];
  assign scl_rise_s = scl_s & ~scl_h;
  assign scl_fall_s = ~scl_s & scl_h;
  assign start_s    = scl_s & sda_h & ~sda_s;
  assign stop_s     = scl_s & ~sda_h & sda_s;
  assign rx_byte_s  = {shift_q[DATA_WIDTH-2:0], sda_s};
  assign rd_byte_s  = mem_q[ptr_q];
  assign ptr_inc_s  = ptr_q + REGISTER_ADDRESS_WIDTH'(1);

  assign sda_oen   = sda_oen_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign dbg_data  = mem_q[dbg_addr];

  // Pad synchronizers; reset to the idle-bus level so no false edge follows reset
  always_ff @(posedge pclk) begin
    if (areset) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], scl_i};
      sda_sync_q <= {sda_sync_q[1:0], sda_i};
    end
  end

  // Protocol state and output registers
  always_ff @(posedge pclk) begin
    if (areset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= {DATA_WIDTH{1'b0}};
      ptr_q       <= {REGISTER_ADDRESS_WIDTH{1'b0}};
      rw_q        <= 1'b0;
      sda_oen_q   <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= {REGISTER_ADDRESS_WIDTH{1'b0}};
      wr_data_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oen_q   <= sda_oen_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Register file: cleared by reset, written at the pointer on a completed byte
  always_ff @(posedge pclk) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (mem_we_s) begin
      mem_q[ptr_q] <= rx_byte_s;
    end else begin
      mem_q[ptr_q] <= mem_q[ptr_q];
    end
  end

  // Next-state logic. bit_cnt==8 means "byte complete, waiting for the ACK slot".
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oen_d   = sda_oen_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we_s    = 1'b0;

    if (start_s) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oen_d = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_s) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      sda_oen_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR, REG_PTR, WR_DATA: begin
          if (scl_rise_s && (bit_cnt_q < 4'd8)) begin
            shift_d   = rx_byte_s;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == ADDR) begin
                if (rx_byte_s[DATA_WIDTH-1:1] == slave_address) begin
                  busy_d = 1'b1;
                  rw_d   = rx_byte_s[0];
                end else begin
                  state_d   = WAIT_STOP;
                  bit_cnt_d = 4'd0;
                end
              end else if (state_q == REG_PTR) begin
                ptr_d = rx_byte_s;
              end else begin
                mem_we_s    = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = rx_byte_s;
                ptr_d       = ptr_inc_s;
              end
            end else begin
              ptr_d = ptr_q;
            end
          end else if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
            // Pull SDA low for the ACK slot
            sda_oen_d = 1'b1;
            bit_cnt_d = 4'd0;
            case (state_q)
              ADDR:    state_d = ADDR_ACK;
              REG_PTR: state_d = PTR_ACK;
              default: state_d = WR_ACK;
            endcase
          end else begin
            state_d = state_q;
          end
        end

        ADDR_ACK: begin
          if (scl_fall_s) begin
            if (rw_q) begin
              // First read bit goes out on the same edge that ends the ACK
              shift_d   = rd_byte_s;
              sda_oen_d = ~rd_byte_s[DATA_WIDTH-1];
              bit_cnt_d = 4'd1;
              state_d   = RD_DATA;
            end else begin
              sda_oen_d = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = REG_PTR;
            end
          end else begin
            state_d = state_q;
          end
        end

        PTR_ACK, WR_ACK: begin
          if (scl_fall_s) begin
            sda_oen_d = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = WR_DATA;
          end else begin
            state_d = state_q;
          end
        end

        RD_DATA: begin
          // bit_cnt counts bits already placed on SDA
          if (scl_fall_s) begin
            if (bit_cnt_q < 4'd8) begin
              shift_d   = shift_q << 1;
              sda_oen_d = ~shift_q[DATA_WIDTH-2];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
              sda_oen_d = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = RD_ACK;
            end
          end else begin
            state_d = state_q;
          end
        end

        RD_ACK: begin
          // bit_cnt==1 records that the master acknowledged
          if (scl_rise_s) begin
            if (!sda_s) begin
              ptr_d     = ptr_inc_s;
              bit_cnt_d = 4'd1;
            end else begin
              bit_cnt_d = 4'd0;
              state_d   = WAIT_STOP;
            end
          end else if (scl_fall_s && (bit_cnt_q == 4'd1)) begin
            shift_d   = rd_byte_s;
            sda_oen_d = ~rd_byte_s[DATA_WIDTH-1];
            bit_cnt_d = 4'd1;
            state_d   = RD_DATA;
          end else begin
            state_d = state_q;
          end
        end

        IDLE, WAIT_STOP: begin
          sda_oen_d = 1'b0;
        end

        default: begin
          state_d   = IDLE;
          bit_cnt_d = 4'd0;
          sda_oen_d = 1'b0;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_responder
//   Directed bench: a bit-banged I2C master drives scl/sda through an
//   open-drain model, and every result is compared with hand-computed values.
// ---------------------------------------------------------------------------
module tb_i2c_slave_responder;

  logic       pclk;
  logic       areset;
  logic [6:0] slave_address;
  logic       scl_i, sda_i;
  logic       sda_oen, busy, wr_strobe;
  logic [7:0] wr_addr, wr_data, dbg_addr, dbg_data;

  logic scl_m, sda_m;

  int checks_cnt;
  int errors_cnt;

  // strobe log and activity counters, written only by the monitor below
  int         strobe_cnt;
  logic [7:0] log_addr [16];
  logic [7:0] log_data [16];
  int         oen_cycles;
  int         busy_cycles;

  logic       ack, oen_ack;
  logic [7:0] rd, pv;
  int         oen0, busy0;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oen;

  i2c_slave_responder dut (
    .pclk          (pclk),
    .areset        (areset),
    .slave_address (slave_address),
    .scl_i         (scl_i),
    .sda_i         (sda_i),
    .sda_oen       (sda_oen),
    .busy          (busy),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    strobe_cnt  = 0;
    oen_cycles  = 0;
    busy_cycles = 0;
  end

  always @(posedge pclk) begin
    if (wr_strobe) begin
      if (strobe_cnt < 16) begin
        log_addr[strobe_cnt] = wr_addr;
        log_data[strobe_cnt] = wr_data;
      end
      strobe_cnt = strobe_cnt + 1;
    end
    if (sda_oen) oen_cycles = oen_cycles + 1;
    if (busy) busy_cycles = busy_cycles + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_cnt = checks_cnt + 1;
    if (obs !== exp_v) begin
      errors_cnt = errors_cnt + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; #100;
    scl_m = 1'b0;
  endtask

  task automatic i2c_rstart();
    #50 sda_m = 1'b1;
    #50 scl_m = 1'b1;
    #100 sda_m = 1'b0;
    #100 scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    #50 sda_m = 1'b0;
    #50 scl_m = 1'b1;
    #100 sda_m = 1'b1;
    #100;
  endtask

  task automatic send_bit(input logic b);
    #50 sda_m = b;
    #50 scl_m = 1'b1;
    #100 scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    #50 sda_m = 1'b1;
    #50 scl_m = 1'b1;
    #50 a = ~sda_i;
    #50 scl_m = 1'b0;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d, output logic oen_at_ack);
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #50 sda_m = 1'b1;
      #50 scl_m = 1'b1;
      #50 d = {d[6:0], sda_i};
      #50 scl_m = 1'b0;
    end
    #50 sda_m = ~mack;
    #50 scl_m = 1'b1;
    #50 oen_at_ack = sda_oen;
    #50 scl_m = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, output logic [7:0] v);
    dbg_addr = a;
    #10 v = dbg_data;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks_cnt    = 0;
    errors_cnt    = 0;
    areset        = 1'b1;
    scl_m         = 1'b1;
    sda_m         = 1'b1;
    slave_address = 7'h50;
    dbg_addr      = 8'h00;
    #40;
    check_val("rst_oen", {31'd0, sda_oen}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_strobe", {31'd0, wr_strobe}, 32'd0);
    check_val("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check_val("rst_wr_data", {24'd0, wr_data}, 32'd0);
    areset = 1'b0;
    #100;

    // write burst: ptr 0x10, data 0x3C, 0x5A
    i2c_start();
    send_byte(8'hA0, ack); check_val("wb_addr_ack", {31'd0, ack}, 32'd1);
    check_val("wb_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h10, ack); check_val("wb_ptr_ack", {31'd0, ack}, 32'd1);
    send_byte(8'h3C, ack); check_val("wb_d0_ack", {31'd0, ack}, 32'd1);
    send_byte(8'h5A, ack); check_val("wb_d1_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    check_val("wb_busy_after", {31'd0, busy}, 32'd0);
    check_val("wb_strobes", strobe_cnt, 32'd2);
    check_val("wb_s0_addr", {24'd0, log_addr[0]}, 32'h10);
    check_val("wb_s0_data", {24'd0, log_data[0]}, 32'h3C);
    check_val("wb_s1_addr", {24'd0, log_addr[1]}, 32'h11);
    check_val("wb_s1_data", {24'd0, log_data[1]}, 32'h5A);
    peek(8'h10, pv); check_val("wb_mem10", {24'd0, pv}, 32'h3C);
    peek(8'h11, pv); check_val("wb_mem11", {24'd0, pv}, 32'h5A);

    // combined read with repeated start
    i2c_start();
    send_byte(8'hA0, ack); check_val("cr_addr_ack", {31'd0, ack}, 32'd1);
    send_byte(8'h10, ack); check_val("cr_ptr_ack", {31'd0, ack}, 32'd1);
    i2c_rstart();
    send_byte(8'hA1, ack); check_val("cr_raddr_ack", {31'd0, ack}, 32'd1);
    recv_byte(1'b1, rd, oen_ack);
    check_val("cr_rd0", {24'd0, rd}, 32'h3C);
    check_val("cr_rd0_rel", {31'd0, oen_ack}, 32'd0);
    recv_byte(1'b0, rd, oen_ack);
    check_val("cr_rd1", {24'd0, rd}, 32'h5A);
    check_val("cr_nack_rel", {31'd0, oen_ack}, 32'd0);
    i2c_stop();
    check_val("cr_strobes", strobe_cnt, 32'd2);
    check_val("cr_busy_after", {31'd0, busy}, 32'd0);

    // address mismatch: 0xA2 is address 0x51
    oen0  = oen_cycles;
    busy0 = busy_cycles;
    i2c_start();
    send_byte(8'hA2, ack); check_val("mm_addr_nack", {31'd0, ack}, 32'd0);
    send_byte(8'h10, ack); check_val("mm_b1_nack", {31'd0, ack}, 32'd0);
    send_byte(8'h55, ack); check_val("mm_b2_nack", {31'd0, ack}, 32'd0);
    send_byte(8'h66, ack); check_val("mm_b3_nack", {31'd0, ack}, 32'd0);
    i2c_stop();
    check_val("mm_oen_cycles", oen_cycles - oen0, 32'd0);
    check_val("mm_busy_cycles", busy_cycles - busy0, 32'd0);
    check_val("mm_strobes", strobe_cnt, 32'd2);
    peek(8'h10, pv); check_val("mm_mem10", {24'd0, pv}, 32'h3C);

    // pointer wrap: write at 0xFF, then read back across the wrap
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h11, ack); check_val("pw_d0_ack", {31'd0, ack}, 32'd1);
    send_byte(8'h22, ack); check_val("pw_d1_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    check_val("pw_strobes", strobe_cnt, 32'd4);
    check_val("pw_s3_addr", {24'd0, log_addr[3]}, 32'h00);
    peek(8'hFF, pv); check_val("pw_memff", {24'd0, pv}, 32'h11);
    peek(8'h00, pv); check_val("pw_mem00", {24'd0, pv}, 32'h22);
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'hFF, ack);
    i2c_rstart();
    send_byte(8'hA1, ack);
    recv_byte(1'b1, rd, oen_ack); check_val("pw_rd0", {24'd0, rd}, 32'h11);
    recv_byte(1'b0, rd, oen_ack); check_val("pw_rd1", {24'd0, rd}, 32'h22);
    i2c_stop();

    // reset while ACKing the address byte
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'hA0 >> i) & 8'h01) != 8'h00);
    #50 sda_m = 1'b1;
    #50 scl_m = 1'b1;
    #50;
    check_val("ra_oen_before", {31'd0, sda_oen}, 32'd1);
    check_val("ra_busy_before", {31'd0, busy}, 32'd1);
    areset = 1'b1;
    @(posedge pclk);
    #1;
    check_val("ra_oen_after", {31'd0, sda_oen}, 32'd0);
    check_val("ra_busy_after", {31'd0, busy}, 32'd0);
    #4 areset = 1'b0;
    peek(8'h10, pv); check_val("ra_mem10", {24'd0, pv}, 32'h00);
    #40 scl_m = 1'b0;
    i2c_stop();
    i2c_start();
    send_byte(8'hA0, ack); check_val("ra_n_addr_ack", {31'd0, ack}, 32'd1);
    send_byte(8'h30, ack);
    send_byte(8'h77, ack); check_val("ra_n_d_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    check_val("ra_strobes", strobe_cnt, 32'd5);
    check_val("ra_s4_addr", {24'd0, log_addr[4]}, 32'h30);
    check_val("ra_s4_data", {24'd0, log_data[4]}, 32'h77);
    peek(8'h30, pv); check_val("ra_mem30", {24'd0, pv}, 32'h77);

    // STOP after four data bits
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h20, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    check_val("sm_strobes", strobe_cnt, 32'd5);
    check_val("sm_oen", {31'd0, sda_oen}, 32'd0);
    check_val("sm_busy", {31'd0, busy}, 32'd0);
    peek(8'h20, pv); check_val("sm_mem20", {24'd0, pv}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- Synthesizable I2C target (slave) responder, the device-side counterpart to the I2C master transfers used by the AVIP.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit slave address, accepts a register pointer byte, then services write and read bursts against an internal byte-wide register file with pointer auto-increment.
- Sits in hdl_top behind the open-drain pad model, so master-side sequences have a real RTL responder.

Parameters:
- SLAVE_ADDRESS_WIDTH, 7, address bits compared in the address byte.
- REGISTER_ADDRESS_WIDTH, 8, pointer width; register file depth is 2**REGISTER_ADDRESS_WIDTH.
- DATA_WIDTH, 8, bits per data byte; fixed at 8 for I2C.

Ports:
- pclk  input  1  system clock; must be ≥8x the SCL frequency.
- areset  input  1  reset, synchronous to pclk, active-high.
- slave_address  input  SLAVE_ADDRESS_WIDTH  this device's address; static during a transfer.
- scl_i  input  1  SCL pad input.
- sda_i  input  1  SDA pad input.
- sda_oen  output  1  1 = pull SDA low; 0 = release (high-Z).
- busy  output  1  high from an address match until STOP, or until START/address mismatch.
- wr_strobe  output  1  one-pclk pulse per register written.
- wr_addr  output  REGISTER_ADDRESS_WIDTH  address of the written register; valid with wr_strobe.
- wr_data  output  DATA_WIDTH  data written; valid with wr_strobe.
- dbg_addr  input  REGISTER_ADDRESS_WIDTH  backdoor read address.
- dbg_data  output  DATA_WIDTH  combinational register file value at dbg_addr.

Behaviour:
- Input path: scl_i and sda_i each pass through a 2-flop synchronizer plus one history flop.
  - Edges and conditions are detected on synchronized values, 3 pclk after the pin change.
  - scl_rise / scl_fall: SCL 0→1 / 1→0.
  - START: SDA 1→0 while SCL=1.
  - STOP: SDA 0→1 while SCL=1.
- Reset, applied while areset=1 at any pclk edge, including mid-transfer:
  - sda_oen=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0.
  - State = IDLE, pointer=0, bit counter=0.
  - Every register file entry = 0.
- States: IDLE, ADDR, ADDR_ACK, REG_PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- Global transitions:
  - START in any state → ADDR, bit count 0, sda_oen=0. This covers repeated start.
  - STOP in any state → IDLE, sda_oen=0, busy=0.
  - START or STOP wins over any edge detected in the same cycle.
- Bit sampling and bit order:
  - Bits are sampled on scl_rise.
  - Driven bits change only on scl_fall.
  - MSB first.
- ADDR: shift 8 bits (7 address + R/W).
  - At the 8th scl_rise with address == slave_address: busy=1.
  - At the following scl_fall: sda_oen=1, go to ADDR_ACK.
  - Mismatch → WAIT_STOP with sda_oen kept 0.
- ADDR_ACK: at the next scl_fall, sda_oen is released.
  - R/W=0 → REG_PTR.
  - R/W=1 → RD_DATA; load shift register with mem[pointer] and drive its MSB (sda_oen = ~bit) on that same scl_fall.
- REG_PTR: shift 8 bits, then pointer ← byte, ACK as above, → PTR_ACK, then → WR_DATA.
- WR_DATA: shift 8 bits.
  - On the 8th scl_rise: mem[pointer] ← byte; wr_strobe pulses for exactly 1 pclk with wr_addr=pointer and wr_data=byte.
  - Pointer ← pointer+1 modulo 2**REGISTER_ADDRESS_WIDTH (0xFF wraps to 0x00).
  - ACK phase → WR_ACK → WR_DATA.
- RD_DATA: drive bits 6..0 on successive scl_fall, then release SDA on the 8th scl_fall → RD_ACK.
- RD_ACK: sample master ACK on scl_rise.
  - SDA=0 (ACK): pointer+1 (wrap); at the next scl_fall load mem[pointer] and drive its MSB → RD_DATA.
  - SDA=1 (NACK): → WAIT_STOP with SDA released.
- WAIT_STOP: ignore all edges; exit only on START or STOP.
- The pointer persists across transactions until reset, so a write-pointer-then-repeated-start-read works.
- Never drive SDA while in IDLE or WAIT_STOP.

Test Plan:
- Write burst: slave_address=0x50; START, 0xA0, ptr 0x10, data 0x3C, 0x5A, STOP → ACK on all 4 bytes; wr_strobe twice (0x10/0x3C, 0x11/0x5A); dbg_data@0x10=0x3C, @0x11=0x5A; busy low after STOP.
- Combined read: START, 0xA0, ptr 0x10, repeated START, 0xA1, read 2 bytes (ACK then NACK), STOP → SDA carries 0x3C then 0x5A MSB first; SDA released at the NACK bit; no wr_strobe.
- Address mismatch: START, 0xA2 (address 0x51) + 3 bytes → sda_oen stays 0 throughout; busy=0; no writes.
- Pointer wrap: write ptr 0xFF, data 0x11, 0x22 → mem[0xFF]=0x11, mem[0x00]=0x22; then read 2 bytes from ptr 0xFF → 0x11, 0x22.
- Reset mid-operation: assert areset while sda_oen=1 during ADDR_ACK → next pclk sda_oen=0, busy=0, dbg_data@0x10=0; the next full transaction behaves normally.
- STOP mid-byte: STOP after 4 data bits of a write → no wr_strobe; IDLE; sda_oen=0.
